// File: rtl/lzc_normalize.sv
// lzc_normalize: streaming normalizer. Finds the leading (MODE=1) or trailing
// (MODE=0) zero count of each beat and shifts the first set bit to the MSB
// (left shift) or LSB (logical right shift). Valid/ready on both sides.
// Build option: define LZC_NORMALIZE_PIPE2_EN to split the count and the
// barrel shift into two register stages (latency 2, capacity 2). Without it
// the block is a single stage (latency 1, capacity 1).

package cf_math_pkg;
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 1) ? unsigned'($clog2(num_idx)) : 1;
  endfunction
endpackage

// Zero counter. An all-zero input reports WIDTH-1 with empty_o set.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan so that the last hit is the set bit nearest the counted end
  always_comb begin
    cnt_o   = CNT_WIDTH'(WIDTH - 1);
    empty_o = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (in_i[i]) begin
          cnt_o   = CNT_WIDTH'(WIDTH - 1 - i);
          empty_o = 1'b0;
        end
      end else begin
        if (in_i[WIDTH-1-i]) begin
          cnt_o   = CNT_WIDTH'(WIDTH - 1 - i);
          empty_o = 1'b0;
        end
      end
    end
  end

endmodule

module lzc_normalize #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MODE      = 1'b1,
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 w_empty;
  logic                 w_accept;

  lzc #(
    .WIDTH(WIDTH),
    .MODE (MODE)
  ) i_lzc (
    .in_i   (data_i),
    .cnt_o  (w_cnt),
    .empty_o(w_empty)
  );

  // Zero input shifts to zero, so no special case is needed here
  function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] d,
                                                  input logic [CNT_WIDTH-1:0] c);
    return MODE ? (d << c) : (d >> c);
  endfunction

`ifdef LZC_NORMALIZE_PIPE2_EN

  logic                 r1_valid;
  logic [WIDTH-1:0]     r1_data;
  logic [CNT_WIDTH-1:0] r1_cnt;
  logic                 r1_empty;
  logic                 r2_valid;
  logic [WIDTH-1:0]     r2_data;
  logic [CNT_WIDTH-1:0] r2_cnt;
  logic                 r2_empty;
  logic                 w_ready1;
  logic                 w_ready2;
  logic                 w_advance;

  assign w_ready2  = ~r2_valid | ready_i;
  assign w_ready1  = ~r1_valid | w_ready2;
  assign ready_o   = flush_i | w_ready1;
  assign w_accept  = valid_i & w_ready1 & ~flush_i;
  assign w_advance = r1_valid & w_ready2 & ~flush_i;

  // Stage valid bits: flush empties both, otherwise each stage refills when it can move
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else if (flush_i) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      if (w_ready1) r1_valid <= valid_i;
      if (w_ready2) r2_valid <= r1_valid;
    end
  end

  // Stage 1 captures the raw word and its count only on acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r1_data  <= '0;
      r1_cnt   <= '0;
      r1_empty <= 1'b0;
    end else if (w_accept) begin
      r1_data  <= data_i;
      r1_cnt   <= w_cnt;
      r1_empty <= w_empty;
    end
  end

  // Stage 2 captures the shifted word only when a beat moves forward
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r2_data  <= '0;
      r2_cnt   <= '0;
      r2_empty <= 1'b0;
    end else if (w_advance) begin
      r2_data  <= norm_shift(r1_data, r1_cnt);
      r2_cnt   <= r1_cnt;
      r2_empty <= r1_empty;
    end
  end

  assign valid_o = r2_valid;
  assign data_o  = r2_data;
  assign cnt_o   = r2_cnt;
  assign empty_o = r2_empty;

`else

  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_empty;

  assign ready_o  = flush_i | ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o & ~flush_i;

  // Valid bit: flush empties the stage, otherwise it reloads whenever it can move
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (ready_o) begin
      r_valid <= valid_i;
    end
  end

  // Count and shift in one path; result registered only on acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b0;
    end else if (w_accept) begin
      r_data  <= norm_shift(data_i, w_cnt);
      r_cnt   <= w_cnt;
      r_empty <= w_empty;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign cnt_o   = r_cnt;
  assign empty_o = r_empty;

`endif

endmodule

// File: tb/tb_lzc_normalize.sv
// tb_lzc_normalize: drives two 8-bit normalizers (leading and trailing mode)
// with a shared stream and compares both against a queue-based model.
module tb_lzc_normalize;

`ifdef LZC_NORMALIZE_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int CAP = LAT;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       flushI = 1'b0;
  logic       validI = 1'b0;
  logic [7:0] dataI = 8'h00;
  logic       readyI = 1'b1;

  logic       readyL, validL, emptyL;
  logic [7:0] dataL;
  logic [2:0] cntL;
  logic       readyT, validT, emptyT;
  logic [7:0] dataT;
  logic [2:0] cntT;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } beat_t;
  beat_t q[$];

  lzc_normalize #(.WIDTH(8), .MODE(1'b1)) dutL (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flushI), .valid_i(validI), .ready_o(readyL),
    .data_i(dataI), .valid_o(validL), .ready_i(readyI), .data_o(dataL), .cnt_o(cntL),
    .empty_o(emptyL)
  );

  lzc_normalize #(.WIDTH(8), .MODE(1'b0)) dutT (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flushI), .valid_i(validI), .ready_o(readyT),
    .data_i(dataI), .valid_o(validT), .ready_i(readyI), .data_o(dataT), .cnt_o(cntT),
    .empty_o(emptyT)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Normalize by repeated single-bit shifting until the set bit reaches the end
  function automatic void refNorm(input logic [7:0] x, input bit lead,
                                  output logic [7:0] d, output int c, output bit e);
    logic [7:0] v;
    v = x;
    c = 0;
    e = (x == 8'h00);
    if (e) begin
      d = 8'h00;
      c = 7;
      return;
    end
    if (lead) while (v[7] == 1'b0) begin v = v << 1; c++; end
    else      while (v[0] == 1'b0) begin v = v >> 1; c++; end
    d = v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r, input bit f);
    validI = v;
    dataI  = d;
    readyI = r;
    flushI = f;
  endtask

  function automatic logic [7:0] randByte();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h01 << $urandom_range(0, 7);
      default: return 8'($urandom());
    endcase
  endfunction

  // Present one beat with ready_i high and return just after the edge where it shows up
  task automatic sendOne(input logic [7:0] d);
    @(negedge clk);
    applyStimulus(1'b1, d, 1'b1, 1'b0);
    @(posedge clk);
    if (LAT == 2) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      @(posedge clk);
    end
    #1;
  endtask

  // Compare process: just before each rising edge check both DUTs against the
  // model, then after the edge move the model by the handshakes that happened
  initial begin : compareProc
    logic [7:0] eD;
    int         eC;
    bit         eE;
    bit         expReady, expValid, doAcc, doDel, doFlush;
    logic [7:0] accData;
    forever begin
      @(negedge clk);
      #4;
      doAcc = 1'b0;
      doDel = 1'b0;
      doFlush = 1'b0;
      accData = dataI;
      if (rstN) begin
        expValid = (q.size() > 0) && (edgeCnt >= q[0].acc + LAT - 1);
        expReady = flushI || (q.size() < CAP) || readyI;
        checkOutput("readyL", readyL, expReady);
        checkOutput("readyT", readyT, expReady);
        checkOutput("validL", validL, expValid);
        checkOutput("validT", validT, expValid);
        if (expValid) begin
          refNorm(q[0].d, 1'b1, eD, eC, eE);
          checkOutput("dataL", dataL, eD);
          checkOutput("cntL", cntL, eC);
          checkOutput("emptyL", emptyL, eE);
          refNorm(q[0].d, 1'b0, eD, eC, eE);
          checkOutput("dataT", dataT, eD);
          checkOutput("cntT", cntT, eC);
          checkOutput("emptyT", emptyT, eE);
        end
        doFlush = flushI;
        doAcc   = validI && expReady && !flushI;
        doDel   = expValid && readyI && !flushI;
      end else begin
        q.delete();
      end
      @(posedge clk);
      #1;
      edgeCnt++;
      if (doFlush) q.delete();
      else begin
        if (doDel) void'(q.pop_front());
        if (doAcc) q.push_back('{accData, edgeCnt});
      end
    end
  end

  // Main sequence: model pins, directed beats, random stream, flush, reset
  initial begin : stimulusProc
    logic [7:0] mD;
    int         mC;
    bit         mE;

    refNorm(8'b0001_0110, 1'b1, mD, mC, mE);
    checkOutput("pinLeadData", mD, 8'b1011_0000);
    checkOutput("pinLeadCnt", mC, 3);
    refNorm(8'b0110_1000, 1'b0, mD, mC, mE);
    checkOutput("pinTrailData", mD, 8'b0000_1101);
    checkOutput("pinTrailCnt", mC, 3);
    refNorm(8'h00, 1'b1, mD, mC, mE);
    checkOutput("pinZeroCnt", mC, 7);
    checkOutput("pinZeroEmpty", mE, 1);

    #1;
    checkOutput("rstValidL", validL, 0);
    checkOutput("rstDataL", dataL, 0);
    checkOutput("rstCntL", cntL, 0);
    checkOutput("rstEmptyL", emptyL, 0);
    checkOutput("rstReadyL", readyL, 1);
    checkOutput("rstReadyT", readyT, 1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    sendOne(8'b0001_0110);
    checkOutput("dirLeadValid", validL, 1);
    checkOutput("dirLeadData", dataL, 8'b1011_0000);
    checkOutput("dirLeadCnt", cntL, 3);
    checkOutput("dirLeadEmpty", emptyL, 0);
    sendOne(8'b0110_1000);
    checkOutput("dirTrailData", dataT, 8'b0000_1101);
    checkOutput("dirTrailCnt", cntT, 3);
    checkOutput("dirTrailEmpty", emptyT, 0);
    sendOne(8'h00);
    checkOutput("dirZeroDataL", dataL, 8'h00);
    checkOutput("dirZeroCntL", cntL, 7);
    checkOutput("dirZeroEmptyL", emptyL, 1);
    checkOutput("dirZeroCntT", cntT, 7);
    sendOne(8'h80);
    checkOutput("dirMsbData", dataL, 8'h80);
    checkOutput("dirMsbCnt", cntL, 0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 3) != 0, randByte(), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("drainValidL", validL, 0);
    checkOutput("drainValidT", validT, 0);

    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, randByte(), 1'b0, 1'b0);
    end
    @(negedge clk);
    #1;
    checkOutput("fullReadyL", readyL, 0);
    checkOutput("fullValidL", validL, 1);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    #1;
    checkOutput("flushReadyL", readyL, 1);
    @(posedge clk);
    #1;
    checkOutput("postFlushValidL", validL, 0);
    checkOutput("postFlushValidT", validT, 0);
    checkOutput("postFlushReadyL", readyL, 1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    end
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstValidL", validL, 0);
    checkOutput("midRstDataL", dataL, 0);
    checkOutput("midRstCntL", cntL, 0);
    checkOutput("midRstEmptyL", emptyL, 0);
    checkOutput("midRstValidT", validT, 0);
    checkOutput("midRstDataT", dataT, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    sendOne(8'h01);
    checkOutput("postRstValid", validL, 1);
    checkOutput("postRstData", dataL, 8'h80);
    checkOutput("postRstCnt", cntL, 7);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
